uart_input_controller: RTL and testbench
========================================

Name: uart_input_controller

Overview:
- Sequences UART receive bytes into 32-bit words for the writeback/PC-generate stage.
- Buffers assembled words in a small FIFO and presents them on input_ready/input_data to the UART-to-register writeback path.
- Consumes a word when the writeback stage requests one.
- Drives a stall so the PC generator holds while a UART read instruction waits for data.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit word entries; power of two, minimum 2.
- PTR_W, $clog2(FIFO_DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; all state is cleared while reset==0.
- flush  in  1  synchronous clear of the byte assembler and FIFO; has priority over all other events.
- rx_valid  in  1  UART receiver has a byte.
- rx_data  in  8  received byte.
- rx_ready  out  1  byte accepted this cycle when rx_valid && rx_ready.
- req  in  1  writeback holds a UART read (UARTtoReg) and wants a word.
- input_ready  out  1  a word is available on input_data.
- input_data  out  32  head word.
- stall  out  1  req && !input_ready; drives PC hold.
- fifo_count  out  PTR_W+1  number of words held.

Behaviour:
- Reset (reset==0, asynchronous):
  - byte_cnt=0, shift register=0, FIFO pointers=0, count=0.
  - Outputs: input_ready=0, input_data=0, stall=0, fifo_count=0.
  - rx_ready=1 once reset deasserts.
  - A partially assembled word is discarded.
- Assembler states, encoded by byte_cnt:
  - B0→B1→B2→B3→B0, advancing on each accepted byte.
  - Big-endian: the first byte goes to [31:24], the last to [7:0].
  - On acceptance in B3, the full word {sh[23:0], rx_data} is pushed into the FIFO at that same edge and the state returns to B0.
- rx_ready:
  - 1 in B0..B2.
  - In B3: 1 iff !full || pop (simultaneous pop frees a slot).
- pop = req && input_ready.
  - The head entry is removed at the edge.
  - input_data is the registered head entry; the next word is visible the cycle after a pop.
  - input_data = 0 when the FIFO is empty.
- Latency: a final byte accepted at edge N gives input_ready=1 after edge N (one cycle) when the FIFO was empty.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full: count==FIFO_DEPTH; a final byte is back-pressured while full (no overwrite, no drop).
- Empty with req=1: stall=1; no pop occurs.
- Pointers wrap modulo FIFO_DEPTH.
- count ranges over 0..FIFO_DEPTH; fifo_count==count.
- flush==1: byte_cnt=0, count=0, pointers=0 at the edge. No byte is accepted that cycle (rx_ready=0) and no pop occurs.
- req deasserted mid-stall: stall drops combinationally; no state change.

Optional Feature:
- Macro: UART_INPUT_BYPASS_EN.
- Defined:
  - When the FIFO is empty, req=1, byte_cnt==B3 and rx_valid=1, the assembled word is driven combinationally on input_data with input_ready=1 and stall=0.
  - The word is consumed in that cycle and is not written to the FIFO.
  - Zero-cycle latency.
- Undefined: no bypass path; minimum latency is one cycle as described above.

Decomposition:
- Shared package uart_input_pkg:
  - typedef word_t (logic [31:0]).
  - typedef byte_t (logic [7:0]).
  - typedef enum asm_state_t {B0,B1,B2,B3}.
  - localparam BYTES_PER_WORD=4.
- Sub-module word_fifo (parameters FIFO_DEPTH and a width of 32 bits):
  - Ports: push, pop, wdata, rdata, count, full, empty, flush.
  - Asynchronous active-low reset.
- The top level holds the assembler, the handshake logic and the bypass mux.

Test Plan:
- Bytes 0x12,0x34,0x56,0x78 with req=0 → after the 4th byte, input_ready=1, input_data=0x12345678, fifo_count=1, stall=0.
- req=1 with the FIFO empty and no bytes → stall=1 every cycle; feed 0xDE,0xAD,0xBE,0xEF → stall drops one cycle after the 4th byte (or in the same cycle with UART_INPUT_BYPASS_EN); word 0xDEADBEEF popped; fifo_count returns to 0.
- Fill 4 words (0x00000001..0x00000004) with req=0, then 3 bytes of a 5th → rx_ready=0 in B3; assert req for one cycle → pop 0x00000001, final byte accepted in the same cycle, fifo_count stays 4, head becomes 0x00000002.
- Push 6 words while popping after each one → words come out in order, pointers wrap, fifo_count never exceeds 1.
- 2 bytes accepted, then reset=0 for one cycle → byte_cnt=0, fifo_count=0; the next 4 bytes 0xAA,0xBB,0xCC,0xDD give 0xAABBCCDD.
- FIFO holding 2 words with byte_cnt=B2, then flush=1 with rx_valid=1 and req=1 → no pop, no byte accepted, fifo_count=0, input_ready=0 on the next cycle.

Source files
------------

// File: rtl/uart_input_pkg.sv
// Shared types and constants for the UART input controller.
package uart_input_pkg;

    typedef logic [31:0] word_t;
    typedef logic [7:0]  byte_t;

    // Assembler position: how many bytes of the current word have arrived.
    typedef enum logic [1:0] {B0, B1, B2, B3} asm_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Next assembler position after one accepted byte; B3 wraps to B0.
    function automatic asm_state_t next_byte(input asm_state_t s);
        case (s)
            B0:      next_byte = B1;
            B1:      next_byte = B2;
            B2:      next_byte = B3;
            default: next_byte = B0;
        endcase
    endfunction

endpackage

// File: rtl/uart_input_controller_word_fifo.sv
// word_fifo: small circular word buffer with count, full/empty and a
// synchronous flush. The head entry is read straight from the storage
// registers, and reads as zero when the buffer is empty.
module word_fifo #(
    parameter  int FIFO_DEPTH = 4,
    parameter  int WIDTH      = 32,
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    // A push into a full buffer is only legal when a pop frees the slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_input_controller.sv
// uart_input_controller: packs UART bytes big-endian into 32-bit words,
// queues them in word_fifo, and hands them to the writeback stage on req.
// Stalls the PC generator while a UART read waits for data.
// Optional build macro UART_INPUT_BYPASS_EN: when the FIFO is empty and the
// final byte of a word arrives while req is high, the word is delivered in
// the same cycle without passing through the FIFO.
module uart_input_controller
    import uart_input_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    output logic           rx_ready,
    input  logic           req,
    output logic           input_ready,
    output logic [31:0]    input_data,
    output logic           stall,
    output logic [PTR_W:0] fifo_count
);

    asm_state_t  state, state_nxt;
    logic [23:0] sh;
    logic        accept, push, pop_fifo, bypass;
    logic        full, empty;
    word_t       fifo_rdata, asm_word;

    assign asm_word = {sh, rx_data};

    // Handshake, bypass and output muxing.
    always_comb begin
        bypass = 1'b0;
`ifdef UART_INPUT_BYPASS_EN
        bypass = empty && req && (state == B3) && rx_valid && !flush;
`endif
        pop_fifo    = req && !empty && !flush;
        // Final byte needs a free slot unless the same-cycle pop makes one.
        rx_ready    = !flush && ((state != B3) || !full || pop_fifo);
        accept      = rx_valid && rx_ready;
        push        = accept && (state == B3) && !bypass;
        input_ready = !empty || bypass;
        input_data  = bypass ? asm_word : fifo_rdata;
        stall       = req && !input_ready;
    end

    // Assembler next state: flush wins, otherwise advance per accepted byte.
    always_comb begin
        state_nxt = state;
        if (flush)       state_nxt = B0;
        else if (accept) state_nxt = next_byte(state);
    end

    // Assembler state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= B0;
        else        state <= state_nxt;
    end

    // Shift register holding the first three bytes of the current word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      sh <= '0;
        else if (flush)  sh <= '0;
        else if (accept) sh <= {sh[15:0], rx_data};
    end

    word_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop_fifo),
        .wdata (asm_word),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_uart_input_controller.sv
// Self-checking bench for uart_input_controller: expected words are queued
// as their bytes are driven and compared as the DUT delivers them.
module tb_uart_input_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        req;
    logic        input_ready;
    logic [31:0] input_data;
    logic        stall;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_w;

    uart_input_controller #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .req         (req),
        .input_ready (input_ready),
        .input_data  (input_data),
        .stall       (stall),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one byte and hold it until accepted (bounded).
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        while (!rx_ready && waited < 20) begin
            cyc();
            waited++;
        end
        n_cmp++;
        if (!rx_ready) begin
            n_bad++;
            $display("FAIL send_byte_timeout: rx_ready=%0b required 1 for byte %02h", rx_ready, b);
        end
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        sb.push_back(w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    // Request one word and compare it against the scoreboard head.
    task automatic do_pop();
        int waited = 0;
        req = 1'b1;
        #1;
        while (!input_ready && waited < 20) begin
            cyc();
            waited++;
        end
        n_cmp++;
        if (!input_ready || sb.size() == 0) begin
            n_bad++;
            $display("FAIL pop_wait: input_ready=%0b sb_size=%0d required ready with expected word", input_ready, sb.size());
        end else begin
            exp_w = sb.pop_front();
            n_cmp++;
            if (input_data !== exp_w) begin
                n_bad++;
                $display("FAIL pop_data: got %08h required %08h", input_data, exp_w);
            end
        end
        cyc();
        req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; rx_valid = 1'b0; rx_data = '0; req = 1'b0;
        #3;
        n_cmp++;
        if ({input_ready, input_data, stall, fifo_count} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: ready=%0b data=%08h stall=%0b count=%0d required all 0",
                     input_ready, input_data, stall, fifo_count);
        end
        cyc();
        reset = 1'b1;
        cyc();
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_rx_ready: got %0b required 1", rx_ready);
        end
    endtask

    task automatic test_basic();
        send_word(32'h12345678);
        n_cmp++;
        if (input_ready !== 1'b1 || fifo_count !== 3'd1 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_status: ready=%0b count=%0d stall=%0b required 1/1/0", input_ready, fifo_count, stall);
        end
        n_cmp++;
        if (input_data !== 32'h12345678) begin
            n_bad++;
            $display("FAIL basic_head: got %08h required 12345678", input_data);
        end
        do_pop();
        n_cmp++;
        if (fifo_count !== 3'd0) begin
            n_bad++;
            $display("FAIL basic_drain: count=%0d required 0", fifo_count);
        end
    endtask

    task automatic test_stall();
        req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (stall !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_empty: cycle %0d stall=%0b required 1", i, stall);
            end
            cyc();
        end
        sb.push_back(32'hDEADBEEF);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        rx_valid = 1'b1;
        rx_data  = 8'hEF;
        #1;
`ifdef UART_INPUT_BYPASS_EN
        exp_w = sb.pop_front();
        n_cmp++;
        if (stall !== 1'b0 || input_ready !== 1'b1 || input_data !== exp_w) begin
            n_bad++;
            $display("FAIL stall_bypass: stall=%0b ready=%0b data=%08h required 0/1/%08h",
                     stall, input_ready, input_data, exp_w);
        end
        cyc();
        rx_valid = 1'b0;
`else
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_last_byte: stall=%0b required 1", stall);
        end
        cyc();
        rx_valid = 1'b0;
        #1;
        exp_w = sb.pop_front();
        n_cmp++;
        if (stall !== 1'b0 || input_ready !== 1'b1 || input_data !== exp_w) begin
            n_bad++;
            $display("FAIL stall_release: stall=%0b ready=%0b data=%08h required 0/1/%08h",
                     stall, input_ready, input_data, exp_w);
        end
        cyc();
`endif
        n_cmp++;
        if (fifo_count !== 3'd0 || stall !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_after_pop: count=%0d stall=%0b required 0/1", fifo_count, stall);
        end
        req = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_req_drop: stall=%0b required 0", stall);
        end
        cyc();
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) send_word(32'(i));
        n_cmp++;
        if (fifo_count !== 3'd4) begin
            n_bad++;
            $display("FAIL full_count: count=%0d required 4", fifo_count);
        end
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        #1;
        n_cmp++;
        if (rx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_backpressure: rx_ready=%0b required 0", rx_ready);
        end
        cyc();
        n_cmp++;
        if (rx_ready !== 1'b0 || fifo_count !== 3'd4 || input_data !== 32'h1) begin
            n_bad++;
            $display("FAIL full_hold: rx_ready=%0b count=%0d head=%08h required 0/4/00000001",
                     rx_ready, fifo_count, input_data);
        end
        req = 1'b1;
        #1;
        exp_w = sb.pop_front();
        n_cmp++;
        if (rx_ready !== 1'b1 || input_data !== exp_w) begin
            n_bad++;
            $display("FAIL full_pop_push: rx_ready=%0b data=%08h required 1/%08h", rx_ready, input_data, exp_w);
        end
        sb.push_back(32'h5);
        cyc();
        req = 1'b0;
        rx_valid = 1'b0;
        #1;
        n_cmp++;
        if (fifo_count !== 3'd4 || input_data !== 32'h2) begin
            n_bad++;
            $display("FAIL full_after: count=%0d head=%08h required 4/00000002", fifo_count, input_data);
        end
        for (int i = 0; i < 4; i++) do_pop();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            send_word({8'(i + 1), 8'hC3, ~8'(i), 8'h5A});
            n_cmp++;
            if (fifo_count > 3'd1) begin
                n_bad++;
                $display("FAIL b2b_count: word %0d count=%0d required <=1", i, fifo_count);
            end
            do_pop();
        end
        n_cmp++;
        if (fifo_count !== 3'd0) begin
            n_bad++;
            $display("FAIL b2b_drain: count=%0d required 0", fifo_count);
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h01);
        send_byte(8'h02);
        reset = 1'b0;
        #2;
        n_cmp++;
        if (fifo_count !== 3'd0 || input_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_state: count=%0d ready=%0b required 0/0", fifo_count, input_ready);
        end
        cyc();
        reset = 1'b1;
        cyc();
        send_word(32'hAABBCCDD);
        do_pop();
    endtask

    task automatic test_flush();
        send_word(32'h0BADF00D);
        send_word(32'hCAFEBABE);
        send_byte(8'h11);
        send_byte(8'h22);
        flush = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h33;
        req = 1'b1;
        #1;
        n_cmp++;
        if (rx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_rx_ready: got %0b required 0", rx_ready);
        end
        cyc();
        flush = 1'b0;
        rx_valid = 1'b0;
        req = 1'b0;
        #1;
        n_cmp++;
        if (fifo_count !== 3'd0 || input_ready !== 1'b0 || input_data !== 32'h0) begin
            n_bad++;
            $display("FAIL flush_state: count=%0d ready=%0b data=%08h required 0/0/0",
                     fifo_count, input_ready, input_data);
        end
        sb.delete();
        send_word(32'h44556677);
        do_pop();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_flush();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover: %0d words undelivered, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
